// File: rtl/cmd_dispatch_pkg.sv
// Shared command-bus definitions: field layout, target codes, dispatcher
// state encodings and the helpers the executors use to decode commands.
package cmd_dispatch_pkg;

    localparam int unsigned C_CMD_W     = 32;
    localparam int unsigned C_BYTE_W    = 8;
    localparam int unsigned C_CMD_BYTES = 4;
    localparam int unsigned C_TGT_LSB   = 28;
    localparam int unsigned C_TGT_W     = 4;
    localparam int unsigned C_ERR_BIT   = 23;

    localparam logic [C_TGT_W-1:0] C_TARGET_CTL  = 4'd0;
    localparam logic [C_TGT_W-1:0] C_TARGET_TAP  = 4'd1;
    localparam logic [C_TGT_W-1:0] C_TARGET_MEM  = 4'd2;
    localparam logic [C_TGT_W-1:0] C_TARGET_GPIO = 4'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RX   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;

    typedef struct packed {
        logic [C_TGT_W-1:0]         target;
        logic [C_CMD_W-C_TGT_W-1:0] body;
    } cmd_t;

    function automatic logic [C_TGT_W-1:0] cmd_target(input logic [C_CMD_W-1:0] c);
        cmd_t w_c;
        w_c = cmd_t'(c);
        return w_c.target;
    endfunction

    // Error response: the offending command echoed back with the error flag set.
    function automatic logic [C_CMD_W-1:0] set_cmd_err(input logic [C_CMD_W-1:0] c);
        return c | (C_CMD_W'(1) << C_ERR_BIT);
    endfunction

endpackage

// File: rtl/cmd_tx_ser.sv
// 32-bit word to big-endian byte stream serializer with valid/ready output.
module cmd_tx_ser
    import cmd_dispatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [C_CMD_W-1:0] i_word,
    output logic [C_BYTE_W-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               o_done_c
);

    localparam int unsigned IDX_W = $clog2(C_CMD_BYTES);

    logic [C_CMD_W-1:0] r_word;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    logic               w_xfer;

    assign w_xfer   = r_valid && tx_ready;
    assign tx_data  = r_word[C_CMD_W-1 -: C_BYTE_W];
    assign tx_valid = r_valid;
    assign o_done_c = w_xfer && (r_idx == IDX_W'(C_CMD_BYTES - 1));

    // Shift the word left one byte per handshake; the word empties to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_word  <= {r_word[C_CMD_W-C_BYTE_W-1:0], C_BYTE_W'(0)};
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(C_CMD_BYTES - 1)) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Host-link command initiator: assembles commands from rx bytes, strobes the
// executor array, and returns the addressed executor's response as tx bytes.
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int unsigned N_TARGETS = 4,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [C_BYTE_W-1:0]          rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [C_CMD_W-1:0]           cmd,
    output logic                         run,
    input  logic [C_CMD_W*N_TARGETS-1:0] rsp_bus,
    output logic [C_BYTE_W-1:0]          tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(C_CMD_BYTES);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [C_CMD_W-1:0] r_cmd;
    logic               r_run;
    logic               r_err;
    logic               r_rx_ready;
    logic               r_busy;

    logic [2:0]         w_next;
    logic               w_accept;
    logic               w_to_hit;
    logic               w_load;
    logic               w_tx_done;
    logic [C_CMD_W-1:0] w_rsp;

    assign w_accept    = rx_valid && r_rx_ready;
    assign rx_ready    = r_rx_ready;
    assign cmd         = r_cmd;
    assign run         = r_run;
    assign busy        = r_busy;
    assign err_timeout = r_err;

    always_comb begin
        w_next   = r_state;
        w_to_hit = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RX;
            S_RX: begin
                if (w_accept && (r_cnt == CNT_W'(C_CMD_BYTES - 1))) begin
                    w_next = S_RUN;
                end else if (!w_accept && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
                    w_next   = S_IDLE;
                    w_to_hit = 1'b1;
                end
            end
            S_RUN:  w_next = S_WAIT;
            S_WAIT: begin
                w_load = 1'b1;
                w_next = S_TX;
            end
            S_TX:   if (w_tx_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Response mux; unmapped target codes fall through to the error encoding.
    always_comb begin
        w_rsp = set_cmd_err(r_cmd);
        for (int unsigned i = 0; i < N_TARGETS; i++) begin
            if (cmd_target(r_cmd) == C_TGT_W'(i)) begin
                w_rsp = rsp_bus[C_CMD_W*i +: C_CMD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_cmd      <= '0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_run      <= (w_next == S_RUN);
            r_err      <= w_to_hit;
            r_rx_ready <= (w_next == S_IDLE) || (w_next == S_RX);
            r_busy     <= (w_next != S_IDLE);
            if (w_accept) begin
                r_cmd <= {r_cmd[C_CMD_W-C_BYTE_W-1:0], rx_data};
                r_cnt <= (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
            end
            if ((r_state == S_RX) && !w_accept && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    cmd_tx_ser u_tx_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_word   (w_rsp),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .o_done_c (w_tx_done)
    );

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a one-register echo executor on target 1.
module tb_cmd_dispatch;

    localparam int unsigned NT = 4;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [31:0]  cmd;
    logic         run;
    logic [127:0] rsp_bus;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         err_timeout;

    logic [31:0]  rsp0, rsp1, rsp2, rsp3;
    assign rsp_bus = {rsp3, rsp2, rsp1, rsp0};

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int run_cnt = 0;
    int run_cyc = 0;
    int err_cnt = 0;
    int first_tx_cyc = 0;
    int stall_viol = 0;
    int ovl_viol = 0;
    logic prev_valid = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] txq[$];

    cmd_dispatch #(.N_TARGETS(NT), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd         (cmd),
        .run         (run),
        .rsp_bus     (rsp_bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Target 1 executor: registers the command on run.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp1 <= 32'h0;
        else if (run) rsp1 <= cmd;
    end

    always @(negedge clk) begin
        if (run) begin
            run_cnt = run_cnt + 1;
            run_cyc = cyc;
        end
        if (err_timeout) err_cnt = err_cnt + 1;
        if (tx_valid && !prev_valid) first_tx_cyc = cyc;
        if (tx_valid && stall_prev && (tx_data !== prev_data)) stall_viol = stall_viol + 1;
        if (tx_valid && rx_ready) ovl_viol = ovl_viol + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_valid = tx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (txq.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_txv();
        int k = 0;
        @(negedge clk);
        while (!tx_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    function automatic logic [31:0] txword();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = {w[23:0], (i < txq.size()) ? txq[i] : 8'h00};
        return w;
    endfunction

    task automatic clear_mon();
        txq.delete();
        run_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        rsp0 = 32'h0; rsp2 = 32'h0; rsp3 = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", cmd, 32'h0);
        chk("rst_ctl", {27'h0, run, rx_ready, tx_valid, busy, err_timeout}, 32'h0);
        chk("rst_txd", {24'h0, tx_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

        // Basic command to the echo executor.
        clear_mon();
        send_cmd(32'h1000_0001);
        wait_bytes(4);
        chk("basic_cmd", cmd, 32'h1000_0001);
        chk("basic_tx", txword(), 32'h1000_0001);
        chk("basic_latency", first_tx_cyc - run_cyc, 32'd2);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("basic_runs", run_cnt, 32'd1);
        chk("basic_nbytes", txq.size(), 32'd4);
        chk("basic_idle", {30'h0, busy, rx_ready}, 32'h1);

        // Target select.
        rsp0 = 32'hAAAA_AAAA; rsp2 = 32'h1234_5678; rsp3 = 32'h5555_5555;
        clear_mon();
        send_cmd(32'h2000_0000);
        wait_bytes(4);
        wait_idle();
        chk("tgt2_tx", txword(), 32'h1234_5678);
        chk("tgt2_runs", run_cnt, 32'd1);

        // Unmapped target code returns the command with bit 23 set.
        clear_mon();
        send_cmd(32'h7000_00C3);
        wait_bytes(4);
        wait_idle();
        chk("unk_tx", txword(), 32'h7080_00C3);
        chk("unk_runs", run_cnt, 32'd1);

        // Timeout after two bytes.
        clear_mon();
        send_byte(8'h30);
        send_byte(8'h11);
        repeat (15) @(negedge clk);
        chk("to_early", err_cnt, 32'd0);
        chk("to_busy_early", {31'h0, busy}, 32'h1);
        repeat (5) @(negedge clk);
        chk("to_pulse", err_cnt, 32'd1);
        chk("to_noruns", run_cnt, 32'd0);
        chk("to_idle", {30'h0, busy, rx_ready}, 32'h1);
        clear_mon();
        send_cmd(32'h10AB_CDEF);
        wait_bytes(4);
        wait_idle();
        chk("to_next_tx", txword(), 32'h10AB_CDEF);
        chk("to_next_runs", run_cnt, 32'd1);

        // Backpressure: stall 10 cycles, then toggle; rsp changes after capture.
        clear_mon();
        stall_viol = 0;
        ovl_viol = 0;
        rsp2 = 32'hCAFE_F00D;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        send_cmd(32'h2000_0000);
        wait_txv();
        rsp2 = 32'h0000_0000;
        repeat (10) @(negedge clk);
        chk("bp_stalled", txq.size(), 32'd0);
        chk("bp_rx_ready", {31'h0, rx_ready}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 tx_ready = ~tx_ready;
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("bp_tx", txword(), 32'hCAFE_F00D);
        chk("bp_nbytes", txq.size(), 32'd4);
        chk("bp_stable", stall_viol, 32'd0);
        chk("bp_overlap", ovl_viol, 32'd0);

        // Reset after the second tx byte.
        clear_mon();
        @(posedge clk);
        #1 tx_ready = 1'b0;
        send_cmd(32'h1234_ABCD);
        wait_txv();
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        @(negedge clk);
        chk("mrst_bytes", txq.size(), 32'd2);
        chk("mrst_first", {16'h0, txq[0], txq[1]}, 32'h0000_1234);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ctl", {27'h0, run, rx_ready, tx_valid, busy, err_timeout}, 32'h0);
        chk("mrst_cmd", cmd, 32'h0);
        chk("mrst_txd", {24'h0, tx_data}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_after", txq.size(), 32'd2);
        chk("mrst_idle", {30'h0, busy, tx_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
- Front-end initiator for the command bus consumed by the per-target executors (tap_exe and siblings).
- Assembles 32-bit commands from an inbound byte stream and drives `cmd`/`run` to all executors.
- Captures the addressed executor's `rsp` and serializes it back out as 4 bytes.
- Sits between the host link byte interface (UART/USB FIFO) and the executor array.

Parameters:
- N_TARGETS, 4, number of executors on rsp_bus; target codes 0..N_TARGETS-1.
- TIMEOUT, 1000000, max idle clocks between bytes of one command before the partial command is discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  inbound command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready at posedge
- cmd  out  32  assembled command, broadcast to all executors
- run  out  1  one-cycle execute strobe
- rsp_bus  in  32*N_TARGETS  executor responses; target t at bits [32t+31:32t]
- tx_data  out  8  outbound response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte taken when tx_valid && tx_ready at posedge
- busy  out  1  high in any state except IDLE
- err_timeout  out  1  one-cycle pulse when a partial command is dropped

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; cmd=0, run=0, rx_ready=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0.
  - Byte counter and timeout counter cleared.
  - Reset mid-command or mid-response discards everything; no partial bytes are emitted afterwards.
- States: IDLE, RX, RUN, WAIT, TX.
- rx_ready is high only in IDLE and RX; it is low in RUN/WAIT/TX, so there is no overlap between commands.
- Byte order is big-endian:
  - The first accepted byte lands in cmd[31:24], then [23:16], [15:8], [7:0].
  - cmd is shifted in place and is not valid to executors until run.
- IDLE: on an accepted byte, go to RX with count=1.
- RX:
  - Each accepted byte increments count and clears the timeout counter.
  - Acceptance of the 4th byte at edge E leads to RUN; run=1 for exactly the cycle after E.
- Timeout: in RX, each cycle with no accepted byte increments the timeout counter. When it reaches TIMEOUT:
  - the partial command is dropped and the state returns to IDLE;
  - err_timeout pulses for 1 cycle;
  - cmd holds its last value, and run is not asserted.
- RUN:
  - run=1 for one cycle; cmd is stable.
  - Next state is WAIT.
- WAIT: one cycle for the executor's registered rsp to settle. At the end of WAIT, latch the response:
  - Compute t = cmd_target(cmd), using the shared target field.
  - If t < N_TARGETS, latch rsp_bus slice t.
  - Otherwise latch set_cmd_err(cmd), the same error encoding the executors use.
- Response timing: run is high in cycle R, rsp is sampled at the end of cycle R+1, and tx_valid first rises in cycle R+2.
- TX:
  - Emit the latched rsp big-endian (rsp[31:24] first), 4 bytes.
  - tx_data/tx_valid are held stable until tx_ready; there is no timeout on tx.
  - After the 4th handshake, tx_valid drops in the next cycle and the state returns to IDLE.
  - A new rx byte can be accepted in that same IDLE cycle.
- Back-to-back commands: minimum period is 4 rx cycles + RUN + WAIT + 4 tx cycles + 1 IDLE.
- The executor's rsp is captured once. Later changes on rsp_bus during TX do not affect emitted bytes.

Decomposition:
- cmd_defs.vh additions:
  - C_TARGET_* codes;
  - target field position;
  - C_CMD_BYTES=4;
  - state encodings for cmd_dispatch.
- cmd_fncs.vh: reuse cmd_target() and set_cmd_err(); no new functions.
- Sub-module: cmd_tx_ser, a 32-bit to 4-byte valid/ready serializer.
  - It keeps the TX path separate so it can be reused by an async status/event reporter.

Test Plan:
- Basic command: rx bytes 0x10,0x00,0x00,0x01 with target field=TAP=1 and rsp_bus slice1 echoing cmd.
  - Expect cmd=0x10000001 and a single run pulse.
  - Expect tx bytes 0x10,0x00,0x00,0x01, with tx_valid first at run+2 cycles.
- Target select: slice0=0xAAAAAAAA, slice2=0x12345678, cmd targets 2 → tx 0x12,0x34,0x56,0x78.
- Unknown target: target code ≥ N_TARGETS → tx equals set_cmd_err(cmd); run still pulses once.
- Timeout: TIMEOUT=16, send 2 bytes then idle 16 cycles → err_timeout pulses once, no run, state IDLE.
  - A subsequent full 4-byte command executes normally.
- Backpressure: tx_ready held low 10 cycles, then toggling → tx_data stable while stalled; exactly 4 bytes; rx_ready low throughout.
- Reset mid-TX: assert rst_n low after the 2nd tx byte → outputs return to reset values immediately; no further tx bytes after release.
